wide_add_sequencer: RTL and testbench

//  Upstream operand sequencer for the 32-bit carry adder stage (a/b/cin -> c/cout, combinational).

---
 rtl/wide_add_sequencer_pkg.sv | 22 ++
 rtl/wide_add_sequencer_if.sv | 58 +++++
 rtl/wide_add_sequencer.sv | 123 ++++++++++++
 tb/tb_wide_add_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/wide_add_sequencer_pkg.sv
// rtl/wide_add_sequencer_pkg.sv - shared types and defaults for the wide add sequencer
//
// Purpose : FSM state encoding, default geometry and the index-width helper
//           used by the sequencer and its interface.
// Contents: state_t {IDLE, RUN, DONE}, DEF_WORD_W, DEF_NUM_WORDS, idx_width().
package wide_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WORD_W    = 32;
    localparam int DEF_NUM_WORDS = 4;

    // A single-word operand still needs a one-bit index register.
    function automatic int idx_width(input int num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

endpackage

// File: rtl/wide_add_sequencer_if.sv
// rtl/wide_add_sequencer_if.sv - request, adder and result signal bundle
//
// Purpose : Groups the request handshake, the word-serial adder link and the
//           result handshake of the wide add sequencer.
// Modports: slave  - the sequencer (accepts requests, drives the adder, emits results)
//           master - the surrounding parent (issues requests, hosts the adder, sinks results)
// Signals : in_valid/in_ready/in_a/in_b/in_cin   request
//           add_a/add_b/add_cin/add_c/add_cout   adder link
//           out_valid/out_ready/out_sum/out_cout result
//           busy                                 sequencer not idle
interface wide_add_sequencer_if
    import wide_add_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int NUM_WORDS = DEF_NUM_WORDS
);
    localparam int OP_W = WORD_W * NUM_WORDS;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_a;
    logic [OP_W-1:0]   in_b;
    logic              in_cin;

    logic [WORD_W-1:0] add_a;
    logic [WORD_W-1:0] add_b;
    logic              add_cin;
    logic [WORD_W-1:0] add_c;
    logic              add_cout;

    logic              out_valid;
    logic              out_ready;
    logic [OP_W-1:0]   out_sum;
    logic              out_cout;

    logic              busy;

    modport slave (
        input  in_valid, in_a, in_b, in_cin,
        output in_ready,
        output add_a, add_b, add_cin,
        input  add_c, add_cout,
        output out_valid, out_sum, out_cout,
        input  out_ready,
        output busy
    );

    modport master (
        output in_valid, in_a, in_b, in_cin,
        input  in_ready,
        input  add_a, add_b, add_cin,
        output add_c, add_cout,
        input  out_valid, out_sum, out_cout,
        output out_ready,
        input  busy
    );

endinterface

// File: rtl/wide_add_sequencer.sv
// rtl/wide_add_sequencer.sv - word-serial operand sequencer for an external carry adder
//
// Purpose : Accepts one WORD_W*NUM_WORDS-bit add request, feeds an external
//           combinational WORD_W-bit adder one word per cycle (LSW first),
//           chains the carry through a register and presents the wide sum and
//           final carry-out until it is consumed.
// Ports   : clock - rising-edge clock
//           reset - asynchronous, active-high; discards any in-flight operation
//           bus   - wide_add_sequencer_if.slave (request, adder link, result, busy)
// Timing  : accept at edge E, out_valid from edge E+NUM_WORDS; no accept while
//           a result is pending, so the issue period is NUM_WORDS+2 cycles.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int NUM_WORDS = DEF_NUM_WORDS
) (
    input  logic                 clock,
    input  logic                 reset,
    wide_add_sequencer_if.slave  bus
);

    localparam int OP_W  = WORD_W * NUM_WORDS;
    localparam int IDX_W = idx_width(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [IDX_W-1:0]  r_idx;
    logic              r_carry;
    logic [OP_W-1:0]   r_a;
    logic [OP_W-1:0]   r_b;
    logic [OP_W-1:0]   r_sum;

    logic              w_accept;
    logic              w_last_word;

    assign w_accept    = (r_state == IDLE) && bus.in_valid;
    assign w_last_word = (r_idx == LAST_IDX);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and handshake / adder-link outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state  = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        bus.add_a     = '0;
        bus.add_b     = '0;
        bus.add_cin   = 1'b0;

        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                // Word slice mux: the current word of each operand goes to the adder.
                bus.add_a   = r_a[int'(r_idx)*WORD_W +: WORD_W];
                bus.add_b   = r_b[int'(r_idx)*WORD_W +: WORD_W];
                bus.add_cin = r_carry;
                if (w_last_word) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, partial-sum collection, carry chaining
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
        end else if (w_accept) begin
            // Inputs are sampled only here; they may change freely afterwards.
            r_a     <= bus.in_a;
            r_b     <= bus.in_b;
            r_carry <= bus.in_cin;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_sum[int'(r_idx)*WORD_W +: WORD_W] <= bus.add_c;
            r_carry                             <= bus.add_cout;
            if (!w_last_word) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // The sum register is left intact after the result is consumed; after the
    // final word the carry register holds the MSW carry-out.
    assign bus.out_sum  = r_sum;
    assign bus.out_cout = r_carry;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb/tb_wide_add_sequencer.sv - directed scoreboard bench for wide_add_sequencer
module tb_wide_add_sequencer;
    import wide_add_pkg::*;

    localparam int W    = 32;
    localparam int N    = 4;
    localparam int OP_W = W * N;

    logic clk;
    logic rst;
    int   cyc;
    int   compared;
    int   mismatched;
    int   acc_cyc;

    logic [OP_W:0] sb[$];

    wide_add_sequencer_if #(.WORD_W(W), .NUM_WORDS(N)) ifc ();

    wide_add_sequencer #(.WORD_W(W), .NUM_WORDS(N)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (ifc.slave)
    );

    // Combinational reference adder stage sitting beside the sequencer.
    assign {ifc.add_cout, ifc.add_c} = {1'b0, ifc.add_a} + {1'b0, ifc.add_b} + {{W{1'b0}}, ifc.add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input logic cin);
        ifc.in_a     = a;
        ifc.in_b     = b;
        ifc.in_cin   = cin;
        ifc.in_valid = 1'b1;
        sb.push_back({1'b0, a} + {1'b0, b} + {{OP_W{1'b0}}, cin});
        for (int k = 0; k < 40 && !ifc.in_ready; k++) @(negedge clk);
        if (!ifc.in_ready) chk("accept_timeout", {159'b0, ifc.in_ready}, 160'd1);
        @(posedge clk);
        @(negedge clk);
        acc_cyc      = cyc;
        ifc.in_valid = 1'b0;
        ifc.in_a     = {$urandom, $urandom, $urandom, $urandom};
        ifc.in_b     = {$urandom, $urandom, $urandom, $urandom};
        ifc.in_cin   = 1'($urandom);
    endtask

    task automatic compare_out(input string tag);
        logic [OP_W:0] e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 160'd0, 160'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_sum"}, {32'b0, ifc.out_sum}, {32'b0, e[OP_W-1:0]});
            chk({tag, "_cout"}, {159'b0, ifc.out_cout}, {159'b0, e[OP_W]});
        end
    endtask

    // Called at a negedge; waits for the result, checks it and consumes it.
    task automatic recv(input string tag, input int exp_lat);
        for (int k = 0; k < 40 && !ifc.out_valid; k++) @(negedge clk);
        chk({tag, "_valid"}, {159'b0, ifc.out_valid}, 160'd1);
        if (exp_lat >= 0) chk({tag, "_latency"}, 160'(cyc - acc_cyc), 160'(exp_lat));
        compare_out(tag);
        ifc.out_ready = 1'b1;
        @(negedge clk);
        ifc.out_ready = 1'b0;
        chk({tag, "_consumed"}, {159'b0, ifc.out_valid}, 160'd0);
    endtask

    initial begin
        logic [3:0] exp_cin;
        logic       saw_valid;
        logic       got1;
        int         acc1;

        compared      = 0;
        mismatched    = 0;
        cyc           = 0;
        acc_cyc       = 0;
        rst           = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.in_a      = '0;
        ifc.in_b      = '0;
        ifc.in_cin    = 1'b0;
        ifc.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", {159'b0, ifc.out_valid}, 160'd0);
        chk("rst_busy", {159'b0, ifc.busy}, 160'd0);
        chk("rst_in_ready", {159'b0, ifc.in_ready}, 160'd1);
        chk("rst_out_sum", {32'b0, ifc.out_sum}, 160'd0);
        chk("rst_out_cout", {159'b0, ifc.out_cout}, 160'd0);
        chk("rst_add_a", {128'b0, ifc.add_a}, 160'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: reset mid-run discards the operation
        send(128'h5, 128'h7, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {159'b0, ifc.out_valid}, 160'd0);
        chk("midrst_busy", {159'b0, ifc.busy}, 160'd0);
        chk("midrst_in_ready", {159'b0, ifc.in_ready}, 160'd1);
        chk("midrst_out_sum", {32'b0, ifc.out_sum}, 160'd0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        saw_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            saw_valid |= ifc.out_valid;
        end
        chk("midrst_no_result", {159'b0, saw_valid}, 160'd0);

        // 2: simple add with latency check
        send(128'd1, 128'd2, 1'b0);
        recv("t2", 4);

        // 3: full carry ripple
        exp_cin = 4'b1110;
        send({OP_W{1'b1}}, 128'd1, 1'b0);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("t3_add_cin_w%0d", i), {159'b0, ifc.add_cin}, {159'b0, exp_cin[i]});
            @(negedge clk);
        end
        recv("t3", 4);

        // 4: carry-in only, then MSB overflow
        send(128'd0, 128'd0, 1'b1);
        recv("t4a", 4);
        send({1'b1, 127'b0}, {1'b1, 127'b0}, 1'b0);
        recv("t4b", 4);

        // 5: backpressure with an ignored request
        send(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 128'hffff_0000_ffff_0000_1111_2222_3333_4444, 1'b1);
        for (int k = 0; k < 40 && !ifc.out_valid; k++) @(negedge clk);
        ifc.in_valid = 1'b1;
        ifc.in_a     = 128'hdead;
        ifc.in_b     = 128'hbeef;
        for (int k = 0; k < 10; k++) begin
            chk("t5_out_valid", {159'b0, ifc.out_valid}, 160'd1);
            chk("t5_in_ready", {159'b0, ifc.in_ready}, 160'd0);
            chk("t5_out_sum", {32'b0, ifc.out_sum}, {32'b0, sb[0][OP_W-1:0]});
            chk("t5_out_cout", {159'b0, ifc.out_cout}, {159'b0, sb[0][OP_W]});
            chk("t5_add_a_idle", {128'b0, ifc.add_a}, 160'd0);
            @(negedge clk);
        end
        ifc.in_valid = 1'b0;
        recv("t5", -1);
        chk("t5_not_busy", {159'b0, ifc.busy}, 160'd0);
        chk("t5_sb_drained", 160'(sb.size()), 160'd0);

        // 6: back-to-back requests with the sink always ready
        ifc.out_ready = 1'b1;
        ifc.in_a      = 128'h1_0000_0000_ffff_ffff;
        ifc.in_b      = 128'h1;
        ifc.in_cin    = 1'b0;
        ifc.in_valid  = 1'b1;
        sb.push_back({1'b0, ifc.in_a} + {1'b0, ifc.in_b});
        @(posedge clk);
        @(negedge clk);
        acc1       = cyc;
        ifc.in_a   = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
        ifc.in_b   = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
        ifc.in_cin = 1'b1;
        sb.push_back({1'b0, ifc.in_a} + {1'b0, ifc.in_b} + 129'd1);
        got1 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (ifc.out_valid && !got1) begin
                compare_out("t6_first");
                got1 = 1'b1;
            end
            if (ifc.in_ready) break;
            @(negedge clk);
        end
        chk("t6_first_seen", {159'b0, got1}, 160'd1);
        @(posedge clk);
        @(negedge clk);
        acc_cyc      = cyc;
        ifc.in_valid = 1'b0;
        chk("t6_issue_period", 160'(acc_cyc - acc1), 160'd6);
        ifc.out_ready = 1'b0;
        recv("t6_second", 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
